// File: rtl/dll_mode_sequencer.sv
// DDR4 DLL-mode / clock-switch sequencer: moves masked ranks between DLL-on/fast and DLL-off/slow.
// Optional build macro ZQ_AFTER_DLL_EN adds a ZQCL + tZQoper wait at the end of the DLL-on path.
module dll_mode_sequencer #(
   parameter int ADDR_WIDTH = 17,
   parameter int BANK_WIDTH = 2,
   parameter int BG_WIDTH   = 2,
   parameter int NUM_RANKS  = 1,
   parameter int WAIT_W     = 12,
   parameter int T_PRE      = 5,
   parameter int T_MOD      = 24,
   parameter int T_CKSRE    = 300,
   parameter int T_CKSRX    = 300,
   parameter int T_XS       = 1000,
   parameter int T_DLLK     = 256,
   parameter int T_ZQOPER   = 128
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   input  logic                      req_dll_on,
   input  logic [NUM_RANKS-1:0]      req_rank,
   input  logic [13:0]               mr0_value,
   input  logic [13:0]               mr1_value,
   output logic                      req_ready,
   output logic                      busy,
   output logic                      done,
   output logic                      dll_on,
   output logic                      clk_sel,
   output logic [7:0]                mc_ACT_n,
   output logic [ADDR_WIDTH*8-1:0]   mc_ADR,
   output logic [BANK_WIDTH*8-1:0]   mc_BA,
   output logic [BG_WIDTH*8-1:0]     mc_BG,
   output logic [NUM_RANKS*8-1:0]    mc_CS_n,
   output logic [NUM_RANKS*8-1:0]    mc_CKE
);

   typedef enum logic [3:0] {
      IDLE, PREA, W_PRE, MRS1, W_MOD, SRE, W_CKSRE, CLKSW,
      W_CKSRX, SRX, W_XS, MRS0, W_DLLK, ZQCL, W_ZQ, DONE
   } state_t;

   state_t                    r_state, w_nstate;
   logic [WAIT_W-1:0]         r_wait, w_wait_load;
   logic                      w_wait_done;
   logic                      r_tgt;
   logic [NUM_RANKS-1:0]      r_rank;
   logic                      r_dll_on, r_clk_sel;
   logic                      w_accept;

   logic                      w_cmd, w_cke_low;
   logic [ADDR_WIDTH-1:0]     w_adr;
   logic [BANK_WIDTH-1:0]     w_ba;
   logic [BG_WIDTH-1:0]       w_bg;

   logic [ADDR_WIDTH*8-1:0]   w_adr_slots, r_adr_slots;
   logic [BANK_WIDTH*8-1:0]   w_ba_slots, r_ba_slots;
   logic [BG_WIDTH*8-1:0]     w_bg_slots, r_bg_slots;
   logic [NUM_RANKS*8-1:0]    w_cs_slots, r_cs_slots;
   logic [NUM_RANKS*8-1:0]    w_cke_slots, r_cke_slots;

   assign req_ready   = (r_state == IDLE);
   assign busy        = (r_state != IDLE) && (r_state != DONE);
   assign done        = (r_state == DONE);
   assign dll_on      = r_dll_on;
   assign clk_sel     = r_clk_sel;
   assign mc_ACT_n    = 8'hFF;
   assign mc_ADR      = r_adr_slots;
   assign mc_BA       = r_ba_slots;
   assign mc_BG       = r_bg_slots;
   assign mc_CS_n     = r_cs_slots;
   assign mc_CKE      = r_cke_slots;

   assign w_accept    = req_valid && req_ready;
   assign w_wait_done = (r_wait == '0);

   // Next state and the wait count to load when a wait state is entered
   always_comb begin
      w_nstate    = r_state;
      w_wait_load = '0;
      case (r_state)
         IDLE:    if (req_valid)
                     w_nstate = ((req_dll_on == r_dll_on) || (req_rank == '0)) ? DONE : PREA;
         PREA:    w_nstate = W_PRE;
         W_PRE:   if (w_wait_done) w_nstate = r_tgt ? SRE : MRS1;
         MRS1:    w_nstate = W_MOD;
         W_MOD:   if (w_wait_done) w_nstate = r_tgt ? MRS0 : SRE;
         SRE:     w_nstate = W_CKSRE;
         W_CKSRE: if (w_wait_done) w_nstate = CLKSW;
         CLKSW:   w_nstate = W_CKSRX;
         W_CKSRX: if (w_wait_done) w_nstate = SRX;
         SRX:     w_nstate = W_XS;
         W_XS:    if (w_wait_done) w_nstate = r_tgt ? MRS1 : DONE;
         MRS0:    w_nstate = W_DLLK;
`ifdef ZQ_AFTER_DLL_EN
         W_DLLK:  if (w_wait_done) w_nstate = ZQCL;
`else
         W_DLLK:  if (w_wait_done) w_nstate = DONE;
`endif
         ZQCL:    w_nstate = W_ZQ;
         W_ZQ:    if (w_wait_done) w_nstate = DONE;
         DONE:    w_nstate = IDLE;
         default: w_nstate = IDLE;
      endcase
      case (w_nstate)
         W_PRE:   w_wait_load = WAIT_W'(T_PRE);
         W_MOD:   w_wait_load = WAIT_W'(T_MOD);
         W_CKSRE: w_wait_load = WAIT_W'(T_CKSRE);
         W_CKSRX: w_wait_load = WAIT_W'(T_CKSRX);
         W_XS:    w_wait_load = WAIT_W'(T_XS);
         W_DLLK:  w_wait_load = WAIT_W'(T_DLLK);
         W_ZQ:    w_wait_load = WAIT_W'(T_ZQOPER);
         default: w_wait_load = '0;
      endcase
   end

   // Command decode for the current state; A[AW-1:AW-3] = RAS/CAS/WE
   always_comb begin
      w_cmd     = 1'b0;
      w_cke_low = 1'b0;
      w_adr     = '0;
      w_ba      = '0;
      w_bg      = '0;
      case (r_state)
         PREA: begin
            w_cmd                   = 1'b1;
            w_adr[10]               = 1'b1;
            w_adr[ADDR_WIDTH-1 -: 3] = 3'b010;
         end
         MRS1: begin
            w_cmd                   = 1'b1;
            w_adr[13:0]             = (mr1_value & 14'h3FFE) | {13'b0, r_tgt};
            w_adr[ADDR_WIDTH-1 -: 3] = 3'b000;
            w_ba                    = BANK_WIDTH'(1);
         end
         MRS0: begin
            w_cmd                   = 1'b1;
            w_adr[13:0]             = mr0_value | 14'h0100;
            w_adr[ADDR_WIDTH-1 -: 3] = 3'b000;
         end
         SRE: begin
            w_cmd                   = 1'b1;
            w_cke_low               = 1'b1;
            w_adr[ADDR_WIDTH-1 -: 3] = 3'b001;
         end
         W_CKSRE, CLKSW, W_CKSRX: w_cke_low = 1'b1;
         ZQCL: begin
            w_cmd                   = 1'b1;
            w_adr[10]               = 1'b1;
            w_adr[ADDR_WIDTH-1 -: 3] = 3'b110;
         end
         default: ;
      endcase
   end

   // Expand to 8 slots per bit; a command lives in slots [1:0], other slots deselect
   always_comb begin
      w_adr_slots = '1;
      w_ba_slots  = '0;
      w_bg_slots  = '0;
      w_cs_slots  = '1;
      w_cke_slots = '1;
      for (int s = 0; s < 8; s++) begin
         for (int b = 0; b < ADDR_WIDTH; b++)
            w_adr_slots[b*8+s] = (w_cmd && s < 2) ? w_adr[b] : 1'b1;
         for (int b = 0; b < BANK_WIDTH; b++)
            w_ba_slots[b*8+s]  = w_cmd && (s < 2) && w_ba[b];
         for (int b = 0; b < BG_WIDTH; b++)
            w_bg_slots[b*8+s]  = w_cmd && (s < 2) && w_bg[b];
         for (int r = 0; r < NUM_RANKS; r++) begin
            w_cs_slots[r*8+s]  = !(w_cmd && (s < 2) && r_rank[r]);
            w_cke_slots[r*8+s] = !(w_cke_low && r_rank[r]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_wait      <= '0;
         r_tgt       <= 1'b1;
         r_rank      <= '0;
         r_dll_on    <= 1'b1;
         r_clk_sel   <= 1'b0;
         r_adr_slots <= '0;
         r_ba_slots  <= '0;
         r_bg_slots  <= '0;
         r_cs_slots  <= '1;
         r_cke_slots <= '1;
      end else begin
         r_state     <= w_nstate;
         r_adr_slots <= w_adr_slots;
         r_ba_slots  <= w_ba_slots;
         r_bg_slots  <= w_bg_slots;
         r_cs_slots  <= w_cs_slots;
         r_cke_slots <= w_cke_slots;
         if (w_nstate != r_state)
            r_wait <= w_wait_load;
         else if (!w_wait_done)
            r_wait <= r_wait - 1'b1;
         // An empty mask moves no rank, so the reported mode must not move either
         if (w_accept) begin
            r_rank <= req_rank;
            r_tgt  <= (req_rank == '0) ? r_dll_on : req_dll_on;
         end
         if (r_state == CLKSW)
            r_clk_sel <= ~r_tgt;
         if ((w_nstate == DONE) && (r_state != IDLE))
            r_dll_on <= r_tgt;
      end
   end

endmodule

// File: tb/tb_dll_mode_sequencer.sv
// Directed bench for dll_mode_sequencer: table-driven path traces plus hand-written reset/corner cases.
module tb_dll_mode_sequencer;
   localparam int AW = 17, BW = 2, GW = 2, NR = 2;

   logic            clk = 1'b0, rst = 1'b1;
   logic            req_valid = 1'b0, req_dll_on = 1'b0;
   logic [NR-1:0]   req_rank = '0;
   logic [13:0]     mr0_value = 14'h0A30, mr1_value = 14'h0201;
   logic            req_ready, busy, done, dll_on, clk_sel;
   logic [7:0]      mc_ACT_n;
   logic [AW*8-1:0] mc_ADR;
   logic [BW*8-1:0] mc_BA;
   logic [GW*8-1:0] mc_BG;
   logic [NR*8-1:0] mc_CS_n, mc_CKE;

   always #5 clk = ~clk;

   dll_mode_sequencer #(
      .ADDR_WIDTH(AW), .BANK_WIDTH(BW), .BG_WIDTH(GW), .NUM_RANKS(NR), .WAIT_W(12),
      .T_PRE(2), .T_MOD(3), .T_CKSRE(4), .T_CKSRX(4), .T_XS(5), .T_DLLK(6), .T_ZQOPER(3)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_dll_on(req_dll_on),
      .req_rank(req_rank), .mr0_value(mr0_value), .mr1_value(mr1_value),
      .req_ready(req_ready), .busy(busy), .done(done), .dll_on(dll_on), .clk_sel(clk_sel),
      .mc_ACT_n(mc_ACT_n), .mc_ADR(mc_ADR), .mc_BA(mc_BA), .mc_BG(mc_BG),
      .mc_CS_n(mc_CS_n), .mc_CKE(mc_CKE)
   );

   // slot word: {BA1, BA0, RAS, CAS, WE, A10, A9, A8, A0}
   localparam logic [8:0] C_NONE = 9'h000, C_ALL = 9'h1FF;
   localparam logic [8:0] E_PREA = {2'b00, 3'b010, 4'b1000}, C_PREA = {2'b00, 3'b111, 4'b1000};
   localparam logic [8:0] E_SRE  = {2'b00, 3'b001, 4'b0000}, C_SRE  = {2'b00, 3'b111, 4'b0000};
   localparam logic [8:0] E_ZQ   = {2'b00, 3'b110, 4'b1000}, C_ZQ   = {2'b00, 3'b111, 4'b1000};
   localparam logic [8:0] E_M1OF = {2'b01, 3'b000, 4'b0100};
   localparam logic [8:0] E_M1ON = {2'b01, 3'b000, 4'b0101};
   localparam logic [8:0] E_M0   = {2'b00, 3'b000, 4'b0110};
`ifdef ZQ_AFTER_DLL_EN
   localparam int ON_DONE = 41;
`else
   localparam int ON_DONE = 36;
`endif

   typedef struct {
      int          n;
      logic [15:0] cs;
      logic [15:0] cke;
      logic [4:0]  flg;   // {clk_sel, done, busy, req_ready, dll_on}
      logic [8:0]  wexp;
      logic [8:0]  wcare;
      string       name;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0, n_bad = 0;

   function automatic logic [8:0] slot_word(input int s);
      return {mc_BA[8+s], mc_BA[s], mc_ADR[16*8+s], mc_ADR[15*8+s], mc_ADR[14*8+s],
              mc_ADR[10*8+s], mc_ADR[9*8+s], mc_ADR[8*8+s], mc_ADR[s]};
   endfunction

   function automatic logic [15:0] cs_of(input logic [1:0] m);
      logic [15:0] c = 16'hFFFF;
      if (m[0]) c[1:0] = 2'b00;
      if (m[1]) c[9:8] = 2'b00;
      return c;
   endfunction

   function automatic logic [15:0] cke_of(input logic [1:0] m);
      logic [15:0] c = 16'hFFFF;
      if (m[0]) c[7:0]  = 8'h00;
      if (m[1]) c[15:8] = 8'h00;
      return c;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input int n, input logic [15:0] cs, input logic [15:0] cke,
                       input logic [4:0] flg, input logic [8:0] we, input logic [8:0] wc,
                       input string nm);
      vec_t v;
      v.n = n; v.cs = cs; v.cke = cke; v.flg = flg; v.wexp = we; v.wcare = wc; v.name = nm;
      tbl.push_back(v);
   endtask

   task automatic fill_off(input logic [1:0] m);
      logic [15:0] c = cs_of(m), k = cke_of(m);
      push(0,  16'hFFFF, 16'hFFFF, 5'b00101, 9'h0,   C_NONE, "off_start");
      push(1,  c,        16'hFFFF, 5'b00101, E_PREA, C_PREA, "off_prea");
      push(2,  16'hFFFF, 16'hFFFF, 5'b00101, 9'h0,   C_NONE, "off_wpre");
      push(4,  16'hFFFF, 16'hFFFF, 5'b00101, 9'h0,   C_NONE, "off_wpre_end");
      push(5,  c,        16'hFFFF, 5'b00101, E_M1OF, C_ALL,  "off_mrs1");
      push(9,  16'hFFFF, 16'hFFFF, 5'b00101, 9'h0,   C_NONE, "off_wmod_end");
      push(10, c,        k,        5'b00101, E_SRE,  C_SRE,  "off_sre");
      push(15, 16'hFFFF, k,        5'b00101, 9'h0,   C_NONE, "off_cksre_end");
      push(16, 16'hFFFF, k,        5'b10101, 9'h0,   C_NONE, "off_clksw");
      push(21, 16'hFFFF, k,        5'b10101, 9'h0,   C_NONE, "off_cksrx_end");
      push(22, 16'hFFFF, 16'hFFFF, 5'b10101, 9'h0,   C_NONE, "off_srx");
      push(27, 16'hFFFF, 16'hFFFF, 5'b10101, 9'h0,   C_NONE, "off_wxs_end");
      push(28, 16'hFFFF, 16'hFFFF, 5'b11000, 9'h0,   C_NONE, "off_done");
      push(29, 16'hFFFF, 16'hFFFF, 5'b10010, 9'h0,   C_NONE, "off_idle");
   endtask

   task automatic fill_on(input logic [1:0] m);
      logic [15:0] c = cs_of(m), k = cke_of(m);
      push(0,  16'hFFFF, 16'hFFFF, 5'b10100, 9'h0,   C_NONE, "on_start");
      push(1,  c,        16'hFFFF, 5'b10100, E_PREA, C_PREA, "on_prea");
      push(4,  16'hFFFF, 16'hFFFF, 5'b10100, 9'h0,   C_NONE, "on_wpre_end");
      push(5,  c,        k,        5'b10100, E_SRE,  C_SRE,  "on_sre");
      push(10, 16'hFFFF, k,        5'b10100, 9'h0,   C_NONE, "on_cksre_end");
      push(11, 16'hFFFF, k,        5'b00100, 9'h0,   C_NONE, "on_clksw");
      push(16, 16'hFFFF, k,        5'b00100, 9'h0,   C_NONE, "on_cksrx_end");
      push(17, 16'hFFFF, 16'hFFFF, 5'b00100, 9'h0,   C_NONE, "on_srx");
      push(23, 16'hFFFF, 16'hFFFF, 5'b00100, 9'h0,   C_NONE, "on_wxs_end");
      push(24, c,        16'hFFFF, 5'b00100, E_M1ON, C_ALL,  "on_mrs1");
      push(28, 16'hFFFF, 16'hFFFF, 5'b00100, 9'h0,   C_NONE, "on_wmod_end");
      push(29, c,        16'hFFFF, 5'b00100, E_M0,   C_ALL,  "on_mrs0");
`ifdef ZQ_AFTER_DLL_EN
      push(37, c,        16'hFFFF, 5'b00100, E_ZQ,   C_ZQ,   "on_zqcl");
`endif
      push(ON_DONE-1, 16'hFFFF, 16'hFFFF, 5'b00100, 9'h0, C_NONE, "on_wait_end");
      push(ON_DONE,   16'hFFFF, 16'hFFFF, 5'b01001, 9'h0, C_NONE, "on_done");
      push(ON_DONE+1, 16'hFFFF, 16'hFFFF, 5'b00011, 9'h0, C_NONE, "on_idle");
   endtask

   // Issue one request, then compare every table row at its cycle offset after accept
   task automatic run_tbl(input logic on, input logic [1:0] m, input logic hold, input int last_n);
      int dones = 0;
      @(negedge clk);
      req_valid = 1'b1; req_dll_on = on; req_rank = m;
      @(posedge clk);
      for (int n = 0; n <= last_n; n++) begin
         @(negedge clk);
         if (!hold) req_valid = 1'b0;
         if (done) dones++;
         foreach (tbl[i]) begin
            if (tbl[i].n == n)
               chk(tbl[i].name,
                   {9'd0, mc_CS_n, mc_CKE, clk_sel, done, busy, req_ready, dll_on,
                    slot_word(0) & tbl[i].wcare, slot_word(1) & tbl[i].wcare},
                   {9'd0, tbl[i].cs, tbl[i].cke, tbl[i].flg, tbl[i].wexp & tbl[i].wcare,
                    tbl[i].wexp & tbl[i].wcare});
         end
      end
      req_valid = 1'b0;
      chk("done_count", 64'(dones), 64'd1);
      tbl.delete();
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_flags", {59'd0, clk_sel, done, busy, req_ready, dll_on}, {59'd0, 5'b00011});
      chk("rst_cke",   {48'd0, mc_CKE}, {48'd0, 16'hFFFF});
      chk("rst_cs",    {48'd0, mc_CS_n}, {48'd0, 16'hFFFF});
      chk("rst_adr0",  {63'd0, (mc_ADR == '0)}, 64'd1);
      chk("rst_ba_bg", {32'd0, mc_BA, mc_BG}, 64'd0);
      chk("act_n",     {56'd0, mc_ACT_n}, {56'd0, 8'hFF});
      rst = 1'b0;
      @(negedge clk);
      chk("idle_adr1", {63'd0, (mc_ADR == '1)}, 64'd1);

      // OFF path, rank 0 only
      mr1_value = 14'h0201;
      fill_off(2'b01);
      run_tbl(1'b0, 2'b01, 1'b0, 29);

      // OFF while already off: immediate done, no command
      push(0, 16'hFFFF, 16'hFFFF, 5'b11000, 9'h0, C_NONE, "noop_done");
      push(1, 16'hFFFF, 16'hFFFF, 5'b10010, 9'h0, C_NONE, "noop_idle");
      run_tbl(1'b0, 2'b01, 1'b0, 1);

      // ON path, rank 0 only
      mr1_value = 14'h0200;
      fill_on(2'b01);
      run_tbl(1'b1, 2'b01, 1'b0, ON_DONE + 1);

      // OFF path on rank 1 with req_valid held high the whole time
      mr1_value = 14'h0201;
      fill_off(2'b10);
      run_tbl(1'b0, 2'b10, 1'b1, 29);

      // Empty mask: done next cycle, nothing on the bus, clock untouched
      @(negedge clk);
      req_valid = 1'b1; req_dll_on = 1'b1; req_rank = 2'b00;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("mask0_done", {46'd0, done, busy, clk_sel, mc_CS_n}, {46'd0, 3'b101, 16'hFFFF});
      @(negedge clk);
      chk("mask0_idle", {62'd0, done, req_ready}, {62'd0, 2'b01});

      // ON path on both ranks, reset asserted during W_CKSRE
      mr1_value = 14'h0200;
      @(negedge clk);
      req_valid = 1'b1; req_dll_on = 1'b1; req_rank = 2'b11;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("both_prea_cs", {48'd0, mc_CS_n}, {48'd0, 16'hFCFC});
      repeat (6) @(negedge clk);
      chk("both_cksre_cke", {47'd0, busy, mc_CKE}, {47'd0, 1'b1, 16'h0000});
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_flags", {59'd0, clk_sel, done, busy, req_ready, dll_on}, {59'd0, 5'b00011});
      chk("midrst_cke_cs", {32'd0, mc_CKE, mc_CS_n}, {32'd0, 16'hFFFF, 16'hFFFF});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
